// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store controller: RV32I funct3 codes,
// dram access-size encodings, trap cause codes and FSM state encodings.
package lsu_mem_ctrl_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] W_B = 2'd0;
  localparam logic [1:0] W_H = 2'd1;
  localparam logic [1:0] W_W = 2'd2;

  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DATA  = 2'd2,
    ST_EXC   = 2'd3
  } lsu_state_e;

  // Access size from funct3; any code outside the legal set for the
  // direction (loads 0/1/2/4/5, stores 0/1/2) is handled as a word.
  function automatic logic [1:0] access_size(input logic we, input logic [2:0] f3);
    logic [1:0] sz;
    case (f3)
      F3_LB:   sz = W_B;
      F3_LH:   sz = W_H;
      F3_LW:   sz = W_W;
      F3_LBU:  sz = we ? W_W : W_B;
      F3_LHU:  sz = we ? W_W : W_H;
      default: sz = W_W;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_load_extend.sv
// Combinational load-data extension: selects and sign/zero-extends the
// low byte/halfword of the dram read word according to the load funct3.
// Kept standalone so the writeback path can reuse it.
module lsu_mem_ctrl_load_extend
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rdo,
  output logic [XLEN-1:0] data
);

  // Extension select; unlisted codes pass the full word through
  always_comb begin
    data = rdo;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){rdo[7]}}, rdo[7:0]};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, rdo[7:0]};
      F3_LH:   data = {{(XLEN-16){rdo[15]}}, rdo[15:0]};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, rdo[15:0]};
      default: data = rdo;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the MEM stage and the byte-addressed data
// RAM. One request in flight: IDLE -> ISSUE -> (load) DATA -> IDLE, stores
// finish in ISSUE. Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword
// and word accesses (IDLE -> EXC -> IDLE, no dram access); otherwise the
// exc_* outputs are tied low and the dram handles any alignment.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic [XLEN-1:0]  dram_adr,
  output logic [1:0]       dram_op,
  output logic             dram_we,
  output logic [XLEN-1:0]  dram_wdin,
  input  logic [XLEN-1:0]  dram_rdo,
  output logic             resp_valid,
  output logic             resp_load,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             exc_valid,
  output logic [3:0]       exc_cause,
  output logic [XLEN-1:0]  exc_tval
);

  lsu_state_e       state, state_nx;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [XLEN-1:0]  addr_q;
  logic [XLEN-1:0]  wdata_q;
  logic [TAG_W-1:0] tag_q;
  logic             accept;
  logic             misalign;
  logic [1:0]       size_q;
  logic [XLEN-1:0]  ext_data;

  assign accept = req_valid & req_ready & ~flush;
  assign size_q = access_size(we_q, f3_q);

`ifdef LSU_MISALIGN_TRAP_EN
  logic [1:0] req_size;
  assign req_size = access_size(req_we, req_funct3);
  assign misalign = ((req_size == W_H) && req_addr[0]) ||
                    ((req_size == W_W) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  lsu_mem_ctrl_load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3 (f3_q),
    .rdo    (dram_rdo),
    .data   (ext_data)
  );

  // State register and held request; request fields latch on accept only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      tag_q   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        tag_q   <= req_tag;
      end
    end
  end

  // Next state and all outputs decoded from state; flush gates every pulse
  always_comb begin
    state_nx   = state;
    req_ready  = (state == ST_IDLE);
    dram_adr   = '0;
    dram_op    = 2'b00;
    dram_we    = 1'b0;
    dram_wdin  = '0;
    resp_valid = 1'b0;
    resp_load  = 1'b0;
    resp_data  = '0;
    resp_tag   = '0;
    exc_valid  = 1'b0;
    exc_cause  = 4'd0;
    exc_tval   = '0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nx = misalign ? ST_EXC : ST_ISSUE;
      end
      ST_ISSUE: begin
        dram_adr  = addr_q;
        dram_op   = size_q;
        dram_we   = we_q & ~flush;
        dram_wdin = wdata_q;
        if (we_q && !flush) resp_valid = 1'b1;
        state_nx = (we_q || flush) ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (!flush) begin
          resp_valid = 1'b1;
          resp_load  = 1'b1;
          resp_data  = ext_data;
          resp_tag   = tag_q;
        end
        state_nx = ST_IDLE;
      end
      ST_EXC: begin
`ifdef LSU_MISALIGN_TRAP_EN
        if (!flush) begin
          exc_valid = 1'b1;
          exc_cause = we_q ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
          exc_tval  = addr_q;
        end
`endif
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl with a behavioural byte-addressed
// dram (registered read, write on the issue edge) and a reference byte
// array. Expected responses/traps are queued at accept time and checked
// by a negedge monitor, including the cycle they must appear in.
module tb_lsu_mem_ctrl;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       req_funct3;
  logic [XLEN-1:0]  req_addr;
  logic [XLEN-1:0]  req_wdata;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic [XLEN-1:0]  dram_adr;
  logic [1:0]       dram_op;
  logic             dram_we;
  logic [XLEN-1:0]  dram_wdin;
  logic [XLEN-1:0]  dram_rdo;
  logic             resp_valid;
  logic             resp_load;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             exc_valid;
  logic [3:0]       exc_cause;
  logic [XLEN-1:0]  exc_tval;

  lsu_mem_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_tag(req_tag), .flush(flush),
    .dram_adr(dram_adr), .dram_op(dram_op), .dram_we(dram_we),
    .dram_wdin(dram_wdin), .dram_rdo(dram_rdo),
    .resp_valid(resp_valid), .resp_load(resp_load), .resp_data(resp_data),
    .resp_tag(resp_tag), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_tval(exc_tval)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        ld;
    logic [31:0] data;
    logic [4:0]  tag;
    int          cyc;
  } resp_exp_t;

  typedef struct {
    logic [3:0]  cause;
    logic [31:0] tval;
    int          cyc;
  } exc_exp_t;

  resp_exp_t rq[$];
  exc_exp_t  eq[$];

  logic [7:0] dram_mem [256];
  logic [7:0] ref_mem  [256];
  logic       mem_clr;

  function automatic logic [7:0] idx(input logic [31:0] a, input int k);
    return a[7:0] + 8'(k);
  endfunction

  function automatic logic [7:0] init_byte(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // dram model: byte-addressed, read data registered, write on the issue edge
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) dram_mem[i] <= init_byte(i);
    end else begin
      dram_rdo <= {dram_mem[idx(dram_adr, 3)], dram_mem[idx(dram_adr, 2)],
                   dram_mem[idx(dram_adr, 1)], dram_mem[idx(dram_adr, 0)]};
      if (dram_we) begin
        dram_mem[idx(dram_adr, 0)] <= dram_wdin[7:0];
        if (dram_op != 2'd0) dram_mem[idx(dram_adr, 1)] <= dram_wdin[15:8];
        if (dram_op == 2'd2) begin
          dram_mem[idx(dram_adr, 2)] <= dram_wdin[23:16];
          dram_mem[idx(dram_adr, 3)] <= dram_wdin[31:24];
        end
      end
    end
  end

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return {ref_mem[idx(a, 3)], ref_mem[idx(a, 2)], ref_mem[idx(a, 1)], ref_mem[idx(a, 0)]};
  endfunction

  function automatic logic [31:0] rd_dram(input logic [31:0] a);
    return {dram_mem[idx(a, 3)], dram_mem[idx(a, 2)], dram_mem[idx(a, 1)], dram_mem[idx(a, 0)]};
  endfunction

  function automatic int nbytes(input logic we, input logic [2:0] f3);
    if (we) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ext(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b100:  return {24'd0, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic bit is_mis(input logic we, input logic [2:0] f3, input logic [31:0] a);
    bit m;
    int nb;
    m = 1'b0;
    nb = nbytes(we, f3);
`ifdef LSU_MISALIGN_TRAP_EN
    m = ((nb == 2) && a[0]) || ((nb == 4) && (a[1:0] != 2'b00));
`else
    if (nb == 0) m = 1'b1;
`endif
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Response/trap monitor: every pulse must match the head of its queue
  always @(negedge clk) begin
    resp_exp_t r;
    exc_exp_t  x;
    if (resp_valid === 1'b1) begin
      checks++;
      assert (rq.size() != 0) else begin
        errors++;
        $error("FAIL resp_unexpected got data %h tag %0d want no response", resp_data, resp_tag);
      end
      if (rq.size() != 0) begin
        r = rq.pop_front();
        chk("resp_cycle", cyc, r.cyc);
        chk("resp_load", {31'd0, resp_load}, {31'd0, r.ld});
        chk("resp_data", resp_data, r.data);
        if (r.ld) chk("resp_tag", {27'd0, resp_tag}, {27'd0, r.tag});
      end
    end
    if (exc_valid === 1'b1) begin
      checks++;
      assert (eq.size() != 0) else begin
        errors++;
        $error("FAIL exc_unexpected got cause %0d tval %h want no trap", exc_cause, exc_tval);
      end
      if (eq.size() != 0) begin
        x = eq.pop_front();
        chk("exc_cycle", cyc, x.cyc);
        chk("exc_cause", {28'd0, exc_cause}, {28'd0, x.cause});
        chk("exc_tval", exc_tval, x.tval);
      end
    end
  end

  // Present a request (caller sits just after a posedge), wait for ready,
  // return the accept edge count and queue what the DUT must produce.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] tag, input bit keep,
                        input bit expect_done, output int acc);
    int n;
    resp_exp_t r;
    exc_exp_t  x;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_tag    = tag;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    acc = cyc;
    if (!keep) req_valid = 1'b0;
    if (expect_done) begin
      if (is_mis(we, f3, addr)) begin
        x.cause = we ? 4'd6 : 4'd4;
        x.tval  = addr;
        x.cyc   = acc;
        eq.push_back(x);
      end else if (we) begin
        for (int k = 0; k < nbytes(we, f3); k++) ref_mem[idx(addr, k)] = wd[8*k +: 8];
        r.ld = 1'b0; r.data = 32'd0; r.tag = 5'd0; r.cyc = acc;
        rq.push_back(r);
      end else begin
        r.ld = 1'b1; r.data = ext(f3, rd_ref(addr)); r.tag = tag; r.cyc = acc + 1;
        rq.push_back(r);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, prev_acc, n;
    bit prev_ld, prev_mis;
    logic we;
    logic [2:0] f3;
    logic [2:0] ld_f3 [5];
    logic [31:0] a;
    ld_f3[0] = 3'd0; ld_f3[1] = 3'd1; ld_f3[2] = 3'd2; ld_f3[3] = 3'd4; ld_f3[4] = 3'd5;
    prev_acc = 0; prev_ld = 1'b0; prev_mis = 1'b0;

    rst = 1'b1; mem_clr = 1'b1; flush = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0; req_tag = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);

    @(posedge clk); #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_dram_we", {31'd0, dram_we}, 32'd0);
    chk("rst_dram_adr", dram_adr, 32'd0);
    chk("rst_dram_op", {30'd0, dram_op}, 32'd0);
    chk("rst_dram_wdin", dram_wdin, 32'd0);
    chk("rst_exc_valid", {31'd0, exc_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; mem_clr = 1'b0;

    // Reset in the middle of a store's issue cycle
    do_req(1'b1, 3'd2, 32'h40, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0, acc);
    chk("issue_dram_we", {31'd0, dram_we}, 32'd1);
    chk("issue_dram_adr", dram_adr, 32'h40);
    rst = 1'b1; #1;
    chk("midrst_dram_we", {31'd0, dram_we}, 32'd0);
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_mem40", rd_dram(32'h40), rd_ref(32'h40));

    // Store then load of a word
    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, acc);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 5'd3, 1'b0, 1'b1, acc);

    // Byte/halfword extension
    do_req(1'b1, 3'd0, 32'h20, 32'h00000080, 5'd0, 1'b0, 1'b1, acc);
    do_req(1'b0, 3'd0, 32'h20, 32'h0, 5'd4, 1'b0, 1'b1, acc);
    do_req(1'b0, 3'd4, 32'h20, 32'h0, 5'd5, 1'b0, 1'b1, acc);
    do_req(1'b1, 3'd1, 32'h20, 32'h00008001, 5'd0, 1'b0, 1'b1, acc);
    do_req(1'b0, 3'd1, 32'h20, 32'h0, 5'd6, 1'b0, 1'b1, acc);
    do_req(1'b0, 3'd5, 32'h20, 32'h0, 5'd7, 1'b0, 1'b1, acc);

    // Illegal funct3 codes behave as word accesses
    do_req(1'b1, 3'd5, 32'h50, 32'h11223344, 5'd0, 1'b0, 1'b1, acc);
    do_req(1'b0, 3'd3, 32'h50, 32'h0, 5'd11, 1'b0, 1'b1, acc);
    do_req(1'b0, 3'd7, 32'h50, 32'h0, 5'd12, 1'b0, 1'b1, acc);

    // Misaligned accesses
    do_req(1'b0, 3'd2, 32'h22, 32'h0, 5'd8, 1'b0, 1'b1, acc);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("exc_no_dram_adr", dram_adr, 32'h0);
    chk("exc_no_dram_we", {31'd0, dram_we}, 32'd0);
`endif
    do_req(1'b1, 3'd1, 32'h21, 32'h0000ABCD, 5'd0, 1'b0, 1'b1, acc);
    do_req(1'b0, 3'd2, 32'h20, 32'h0, 5'd9, 1'b0, 1'b1, acc);

    // Flush during a store's issue cycle
    do_req(1'b1, 3'd2, 32'h30, 32'h55AA55AA, 5'd0, 1'b0, 1'b0, acc);
    flush = 1'b1; #1;
    chk("flush_issue_dram_we", {31'd0, dram_we}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_issue_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("flush_issue_mem30", rd_dram(32'h30), rd_ref(32'h30));

    // Flush during a load's data cycle
    do_req(1'b0, 3'd2, 32'h10, 32'h0, 5'd10, 1'b0, 1'b0, acc);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_data_idle", {31'd0, req_ready}, 32'd1);

    // Flush in IDLE blocks acceptance
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
    flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_idle_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b0; flush = 1'b0;
    @(posedge clk); #1;

    // Back-to-back random traffic with req_valid held
    for (int i = 0; i < 8; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = we ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      a  = 32'h80 + 32'($urandom_range(0, 31));
      do_req(we, f3, a, $urandom, 5'(16 + i), 1'b1, 1'b1, acc);
      if (i > 0) chk("b2b_spacing", acc - prev_acc, (!prev_mis && prev_ld) ? 3 : 2);
      prev_acc = acc; prev_ld = !we; prev_mis = is_mis(we, f3, a);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++)
      do_req(1'b0, 3'd2, 32'h80 + 32'(4 * i), 32'h0, 5'(i), 1'b0, 1'b1, acc);

    n = 0;
    while ((rq.size() != 0 || eq.size() != 0) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    chk("resp_queue_drained", rq.size(), 0);
    chk("exc_queue_drained", eq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
